spi_ram_burst_wrapper: RTL and testbench
========================================

Name: spi_ram_burst_wrapper

Overview:
- SPI slave plus on-chip RAM in one block. Addressing and data widths are parametrised.
- Each frame carries one opcode and a start address, followed by a burst of data words. The address auto-increments per word.
- Replaces the fixed 10-bit single-transfer command scheme.
- Sits at chip top. SPI lines are sampled on the system clock `clk`, which is also the SPI bit clock.

Parameters:
- ADDR_WIDTH, 8, address bits shifted per frame.
- DATA_WIDTH, 8, bits per RAM word and per SPI data word.
- MEM_DEPTH, 256, number of RAM words; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  in  1  system/SPI bit clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first, registered.
- busy  out  1  high while a frame is active (state ≠ IDLE).
- cmd_err  out  1  one-cycle pulse on an illegal opcode or an out-of-range start address.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: MISO=0, busy=0, cmd_err=0, state=IDLE, address/shift registers=0. RAM contents are not reset.
- Timing reference: all inputs are sampled on rising clk. Edge n=0 is the first rising edge with SS_n=0.
- States:
  - IDLE: SS_n=0 → OPC. Bit n=0 is taken as opcode MSB.
  - OPC: bits n=0..1 form opcode. 00=WRITE burst, 01=READ burst, 10/11 illegal. Go to ADDR.
  - ADDR: bits n=2..ADDR_WIDTH+1, MSB first.
    - After the last address bit: illegal opcode, or address ≥ MEM_DEPTH → cmd_err pulse for 1 cycle, go to DROP.
    - Otherwise WRITE → WR_DATA, READ → RD_WAIT.
  - WR_DATA: shift in DATA_WIDTH bits per word.
    - Last bit sampled at edge e → RAM write at edge e+1 (1-cycle write latency), then address increments.
    - Shifting of the next word continues without gaps.
  - RD_WAIT: one dummy cycle at edge n=ADDR_WIDTH+2. Synchronous RAM read is issued; MISO=0. Then → RD_DATA.
  - RD_DATA: bit i of word j is driven on MISO from edge n=ADDR_WIDTH+3+j*DATA_WIDTH+i until the next edge.
    - Word j+1 is prefetched while word j shifts out, so there is no gap between words.
    - Address increments once per word.
  - DROP: ignore MOSI, MISO=0, until SS_n=1.
- Address wrap: MEM_DEPTH-1 increments to 0, in both read and write bursts.
- SS_n=1 sampled in any state → IDLE on that edge; MISO=0, busy=0 from that edge.
  - A partially shifted write word is discarded; no RAM write.
  - A write whose last bit was already sampled still commits on the following edge, even if SS_n rises on that edge.
- rst=1 overrides everything, including mid-frame and mid-write-commit. A pending write is cancelled.
- MISO=0 whenever not in RD_DATA. The output is never tristated.
- No read-after-write hazard: reads and writes never coexist in one frame.

Decomposition:
- Package spi_ram_pkg holds:
  - opcode constants OPC_WRITE=2'b00, OPC_READ=2'b01;
  - state enum {IDLE, OPC, ADDR, WR_DATA, RD_WAIT, RD_DATA, DROP};
  - helper function for the wrapped increment.
- One sub-module: spi_ram_mem, a parametrised single-port synchronous RAM with 1-cycle read and a write enable.
- The serial FSM and shift registers live in the top module.

Test Plan (all with ADDR_WIDTH=8, DATA_WIDTH=8, MEM_DEPTH=256):
- Write burst: SS_n low, opcode 00, addr 0x10, data 0xA5, 0x3C, 0xFF, SS_n high → mem[0x10..0x12] = A5, 3C, FF; mem[0x13] unchanged.
- Read burst after the write above: opcode 01, addr 0x10, hold SS_n low for 1+24 bits → MISO=0 during the dummy cycle (n=10), then the stream 0xA5, 0x3C, 0xFF from edge n=11, no gaps.
- Wrap-around:
  - Write 0x11, 0x22 starting at addr 0xFF → mem[0xFF]=0x11, mem[0x00]=0x22.
  - Read from 0xFF returns 0x11 then 0x22.
- Abort: SS_n rises after 5 data bits of the second word of a write from 0x20 → only mem[0x20] written, mem[0x21] unchanged, busy=0 on the abort edge.
- Illegal opcode 11 with addr 0x00 → cmd_err high exactly one cycle at edge n=10, no RAM writes, MISO=0 for the rest of the frame.
  - With MEM_DEPTH=200, addr 0xC8 also gives cmd_err.
- Reset mid-read (rst=1 at edge n=14) → MISO=0, busy=0 next cycle.
  - A following frame behaves normally.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: opcodes, FSM states and wrapped address increment shared by the SPI RAM wrapper.
package spi_ram_pkg;
  localparam logic [1:0] OPC_WRITE = 2'b00;
  localparam logic [1:0] OPC_READ  = 2'b01;
  typedef enum logic [2:0] {IDLE, OPC, ADDR, WR_DATA, RD_WAIT, RD_DATA, DROP} state_t;
  function automatic int wrap_inc(input int a, input int depth);
    return (a >= depth - 1) ? 0 : a + 1;
  endfunction
endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: single-port synchronous RAM with 1-cycle read latency.
module spi_ram_mem #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/spi_ram_burst_wrapper.sv
// spi_ram_burst_wrapper: SPI slave with opcode + start address framing and auto-incrementing
// burst reads/writes into an on-chip RAM; SPI bits are sampled on the system clock.
module spi_ram_burst_wrapper
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic cmd_err
);
  localparam int CW = $clog2(ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1;
  state_t state;
  logic [1:0] opc;
  logic [ADDR_WIDTH-1:0] addr, nxt_addr, addr_inc;
  logic [DATA_WIDTH-1:0] sh, wdata, rdata;
  logic [CW-1:0] cnt;
  logic we, err_pend, bad, last_addr, last_bit;
  assign nxt_addr  = {addr[ADDR_WIDTH-2:0], MOSI};
  assign addr_inc  = ADDR_WIDTH'(wrap_inc(int'(addr), MEM_DEPTH));
  assign last_addr = cnt == CW'(ADDR_WIDTH - 1);
  assign last_bit  = cnt == CW'(DATA_WIDTH - 1);
  assign bad       = !(opc == OPC_WRITE || opc == OPC_READ) || int'(nxt_addr) >= MEM_DEPTH;
  assign busy      = state != IDLE;
  // A committed write lands one edge after its last bit, even if the frame has ended; reset cancels it.
  spi_ram_mem #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .DEPTH(MEM_DEPTH)) u_mem (
    .clk(clk), .we(we & ~rst), .addr(addr), .wdata(wdata), .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      opc      <= '0;
      addr     <= '0;
      sh       <= '0;
      wdata    <= '0;
      cnt      <= '0;
      we       <= 1'b0;
      err_pend <= 1'b0;
      cmd_err  <= 1'b0;
      MISO     <= 1'b0;
    end else begin
      we       <= 1'b0;
      err_pend <= 1'b0;
      cmd_err  <= err_pend;
      MISO     <= 1'b0;
      if (we) addr <= addr_inc;
      if (SS_n) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            opc   <= {opc[0], MOSI};
            state <= OPC;
          end
          OPC: begin
            opc   <= {opc[0], MOSI};
            cnt   <= '0;
            state <= ADDR;
          end
          ADDR: begin
            addr <= nxt_addr;
            cnt  <= last_addr ? '0 : cnt + 1'b1;
            if (last_addr) begin
              err_pend <= bad;
              state    <= bad ? DROP : (opc == OPC_WRITE ? WR_DATA : RD_WAIT);
            end
          end
          WR_DATA: begin
            sh  <= {sh[DATA_WIDTH-2:0], MOSI};
            cnt <= last_bit ? '0 : cnt + 1'b1;
            if (last_bit) begin
              we    <= 1'b1;
              wdata <= {sh[DATA_WIDTH-2:0], MOSI};
            end
          end
          RD_WAIT: state <= RD_DATA;
          // The word is loaded at bit 0; the RAM then prefetches the next address for the following word.
          RD_DATA: begin
            MISO <= cnt == '0 ? rdata[DATA_WIDTH-1] : sh[DATA_WIDTH-1];
            sh   <= (cnt == '0 ? rdata : sh) << 1;
            cnt  <= last_bit ? '0 : cnt + 1'b1;
            if (cnt == '0) addr <= addr_inc;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_ram_burst_wrapper.sv
// tb_spi_ram_burst_wrapper: directed SPI frames with hand-computed expected RAM contents and pin values.
module tb_spi_ram_burst_wrapper;
  logic clk, rst, SS_n, MOSI;
  logic miso, busy, cmd_err, miso2, busy2, cmd_err2;
  int checks = 0;
  int errors = 0;

  spi_ram_burst_wrapper dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso), .busy(busy), .cmd_err(cmd_err)
  );
  spi_ram_burst_wrapper #(.MEM_DEPTH(200)) dut2 (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso2), .busy(busy2), .cmd_err(cmd_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic b);
    SS_n = 1'b0;
    MOSI = b;
    @(negedge clk);
  endtask

  task automatic idle();
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
  endtask

  task automatic hdr(input logic [1:0] o, input logic [7:0] a);
    for (int i = 1; i >= 0; i--) step(o[i]);
    for (int i = 7; i >= 0; i--) step(a[i]);
  endtask

  task automatic wr(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) step(d[i]);
  endtask

  task automatic rd(input string tag, input logic [7:0] e);
    logic [7:0] w;
    for (int i = 7; i >= 0; i--) begin
      step(1'b0);
      w[i] = miso;
    end
    chk(tag, {24'd0, w}, {24'd0, e});
  endtask

  task automatic rd_start(input logic [7:0] a);
    hdr(2'b01, a);
    step(1'b0);
    chk("dummy_miso", {31'd0, miso}, 32'd0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    rst = 1'b0;
    idle();
    // Seed 0x13 so the burst below can be shown not to touch it
    hdr(2'b00, 8'h13); wr(8'h5A); idle();
    hdr(2'b00, 8'h10);
    chk("busy_frame", {31'd0, busy}, 32'd1);
    wr(8'hA5); wr(8'h3C); wr(8'hFF); idle();
    chk("busy_after", {31'd0, busy}, 32'd0);
    idle();
    rd_start(8'h10);
    rd("rd_10", 8'hA5); rd("rd_11", 8'h3C); rd("rd_12", 8'hFF); rd("rd_13", 8'h5A);
    idle();
    chk("miso_idle", {31'd0, miso}, 32'd0);
    // Wrap-around
    hdr(2'b00, 8'hFF); wr(8'h11); wr(8'h22); idle(); idle();
    rd_start(8'hFF); rd("wrap_ff", 8'h11); rd("wrap_00", 8'h22); idle();
    rd_start(8'h00); rd("rd_00", 8'h22); idle();
    // Abort mid-word
    hdr(2'b00, 8'h20); wr(8'h00); wr(8'h77); idle();
    hdr(2'b00, 8'h20); wr(8'h99);
    for (int i = 0; i < 5; i++) step(1'b1);
    idle();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    idle();
    rd_start(8'h20); rd("abort_20", 8'h99); rd("abort_21", 8'h77); idle();
    // Illegal opcode
    hdr(2'b11, 8'h00);
    chk("ill_err_n9", {31'd0, cmd_err}, 32'd0);
    step(1'b1);
    chk("ill_err_n10", {31'd0, cmd_err}, 32'd1);
    step(1'b1);
    chk("ill_err_n11", {31'd0, cmd_err}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(i[0]);
      seen = seen | miso | cmd_err;
    end
    chk("ill_quiet", {31'd0, seen}, 32'd0);
    chk("ill_busy", {31'd0, busy}, 32'd1);
    idle(); idle();
    rd_start(8'h00); rd("ill_nowrite", 8'h22); idle();
    // Out-of-range start address on the 200-word instance
    hdr(2'b00, 8'hC8); step(1'b0);
    chk("oor_err_c8", {31'd0, cmd_err2}, 32'd1);
    chk("inrange_256", {31'd0, cmd_err}, 32'd0);
    idle();
    hdr(2'b00, 8'hC7); step(1'b0);
    chk("oor_err_c7", {31'd0, cmd_err2}, 32'd0);
    idle(); idle();
    // Reset mid-read at edge n=14
    rd_start(8'h10);
    step(1'b0); step(1'b0); step(1'b0);
    chk("pre_rst_bit", {31'd0, miso}, 32'd1);
    rst = 1'b1;
    step(1'b0);
    chk("rst_mid_miso", {31'd0, miso}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(); idle();
    rd_start(8'h10); rd("post_rst", 8'hA5); idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
